terminal_display: RTL and testbench
===================================

// Module: terminal_display
// PURPOSE
//  Consumer end of the terminal write interface: stores characters written on
//  terminal_addr/terminal_write/terminal_data into an 80x30 character RAM.
//  Scans that RAM out as 640x480@60 VGA text using 8x16 glyphs from an
//  external synchronous font ROM. Sits between the debugger/terminal writers
//  and the board VGA pins.
// PARAMETERS
//  COLUMNS   80      characters per row
//  ROWS      30      character rows; RAM depth = COLUMNS*ROWS = 2400
//  FG_COLOR  12'h0F0 {r,g,b} 4b each, lit glyph pixel
//  BG_COLOR  12'h000 {r,g,b} 4b each, unlit pixel and blanking-free background
// PORTS
//  clock           in   1   25 MHz pixel clock; all logic on posedge
//  reset_n         in   1   asynchronous, active-low reset
//  terminal_addr   in   12  cell index = row*80 + column
//  terminal_write  in   1   write strobe, sampled each posedge
//  terminal_data   in   8   character code
//  font_addr       out  12  {char_code[7:0], glyph_row[3:0]}
//  font_data       in   8   glyph row bits, bit7 = leftmost; valid 1 cycle after font_addr
//  vga_hsync       out  1   active-low horizontal sync
//  vga_vsync       out  1   active-low vertical sync
//  vga_red/green/blue out 4 each  pixel colour; 0 outside visible area
// BEHAVIOUR
//  - Reset values: vga_hsync=1, vga_vsync=1, vga_red/green/blue=0, font_addr=0.
//    h_count=v_count=0; pipeline valid bits cleared. RAM contents not reset
//    (initialised to 8'h00 at configuration).
//  - Reset mid-frame: outputs return to reset values immediately (async).
//    Scan restarts at (0,0) on the first posedge after release.
//  - Write: at posedge with terminal_write=1 and terminal_addr<2400,
//    ram[terminal_addr]<=terminal_data. Addresses 2400..4095 are ignored.
//    A write every cycle is sustained; writes never stall.
//  - Counters: h_count 0..799 wraps to 0 and increments v_count; v_count 0..524
//    wraps to 0. Visible when h<640 && v<480.
//  - Raw sync: hsync low for h in 656..751; vsync low for v in 490..491.
//  - Pipeline, all stages registered:
//    S1 reads RAM at (v>>4)*80+(h>>3), read-first.
//    S2 drives font_addr={char, v[3:0]}.
//    S3 receives font_data.
//    S4 drives pixel/sync outputs.
//    Outputs for counter (h,v) appear exactly 4 cycles after the counter holds
//    (h,v). hsync, vsync, visible and h[2:0] are delayed by the same 4 stages.
//  - Pixel: bit = font_data[7-h[2:0]]; colour = bit ? FG_COLOR : BG_COLOR when
//    visible, else 0.
//  - Character code 8'h00 always renders as BG_COLOR regardless of font_data.
//  - Write and scan-read of the same cell in the same cycle: the old character is
//    displayed for that read; the new character is displayed from the next read
//    of that cell.
//  - Address arithmetic: row*80 computed as (row<<6)+(row<<4), 12 bit, no overflow.
// CONFIGURATION
//  TERMINAL_INVERSE_EN defined:
//    - char bit7 selects inverse video: font_addr={1'b0, char[6:0], row}.
//    - Lit glyph bit renders BG_COLOR, unlit bit renders FG_COLOR, within
//      visible area.
//    - Code 8'h80 renders a solid FG_COLOR cell.
//  TERMINAL_INVERSE_EN undefined:
//    - font_addr={char[7:0], row}; no inversion logic synthesised.
// TESTING
//  1 reset_n low mid-line -> hsync=vsync=1, rgb=0 at once. Release -> first
//    hsync falling edge 656+4 clocks after first posedge.
//  2 free run 2 frames -> 800 clocks/line, hsync low 96 clocks; 525 lines/frame,
//    vsync low 1600 clocks.
//  3 write 0x41 to addr 0; ROM model returns 0xA5 for {0x41,0} -> line 0,
//    px 0..7 = FG,BG,FG,BG,BG,FG,BG,FG. Unwritten cell (0x00) with ROM 0xFF -> BG.
//  4 write 0x42 to addr 2399 -> cell shown at h 632..639, v 464..479.
//    Write 0x43 to addr 2400 -> no RAM cell changes.
//  5 write 0x31 then 0x32 to addr 81 in the cycle its scan read occurs -> 0x31
//    glyph on that line, 0x32 from the next line.
//  6 with TERMINAL_INVERSE_EN: write 0xC1 -> font_addr={0x41,row}, pixels
//    inverted. Without it -> font_addr={0xC1,row}, pixels normal.

Source files
------------

// File: rtl/terminal_display_if.sv
// Terminal write bus: a writer presents a cell index, a write strobe and a character code.
interface terminal_display_if;
  logic [11:0] terminal_addr;
  logic        terminal_write;
  logic [7:0]  terminal_data;

  modport master (output terminal_addr, output terminal_write, output terminal_data);
  modport slave  (input terminal_addr, input terminal_write, input terminal_data);
endinterface

// File: rtl/terminal_display.sv
// 80x30 text terminal: character RAM written over the terminal bus, scanned out as
// 640x480@60 VGA via an external synchronous 8x16 font ROM. Option: TERMINAL_INVERSE_EN.
module terminal_display #(
  parameter int unsigned COLUMNS  = 80,
  parameter int unsigned ROWS     = 30,
  parameter logic [11:0] FG_COLOR = 12'h0F0,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  terminal_display_if.slave        term_if,
  output logic [11:0]              font_addr,
  input  logic [7:0]               font_data,
  output logic                     vga_hsync,
  output logic                     vga_vsync,
  output logic [3:0]               vga_red,
  output logic [3:0]               vga_green,
  output logic [3:0]               vga_blue
);

  localparam int unsigned RAM_DEPTH = COLUMNS * ROWS;
  localparam logic [11:0] RAM_LIMIT = 12'(RAM_DEPTH);

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_FIRST = 10'd656;
  localparam logic [9:0] H_SYNC_LAST  = 10'd751;
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_FIRST = 10'd490;
  localparam logic [9:0] V_SYNC_LAST  = 10'd491;
  localparam logic [9:0] V_LAST       = 10'd524;

  typedef struct packed {
    logic       valid;
    logic       visible;
    logic       hsync;
    logic       vsync;
    logic [2:0] hpix;
  } meta_t;

  localparam meta_t META_RESET = '{valid: 1'b0, visible: 1'b0, hsync: 1'b1,
                                   vsync: 1'b1, hpix: 3'd0};

  logic [9:0]  h_count_q, h_count_d;
  logic [9:0]  v_count_q, v_count_d;
  logic        visible_0;
  logic [4:0]  row_0;
  logic [6:0]  col_0;
  logic [11:0] rd_addr_0;
  logic        wr_en;

  logic [7:0]  ram_q [RAM_DEPTH];
  logic [7:0]  s1_char_q;
  meta_t       s1_meta_q, s1_meta_d;
  logic [3:0]  s1_row_q, s1_row_d;

  meta_t       s2_meta_q, s2_meta_d;
  logic [11:0] font_addr_q, font_addr_d;
  logic        s2_blank_q, s2_blank_d;

  meta_t       s3_meta_q;
  logic        s3_blank_q;

  logic        glyph_bit;
  logic        lit;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [11:0] rgb_q, rgb_d;

`ifdef TERMINAL_INVERSE_EN
  logic        s2_inv_q, s2_inv_d;
  logic        s2_solid_q, s2_solid_d;
  logic        s3_inv_q, s3_solid_q;
`endif

  always_comb begin
    h_count_d = h_count_q + 10'd1;
    v_count_d = v_count_q;
    if (h_count_q == H_LAST) begin
      h_count_d = 10'd0;
      v_count_d = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
    end
  end

  // Blanking reads cell 0 so the RAM index always stays inside the array.
  always_comb begin
    visible_0 = (h_count_q < H_VISIBLE) && (v_count_q < V_VISIBLE);
    row_0     = v_count_q[8:4];
    col_0     = h_count_q[9:3];
    rd_addr_0 = 12'd0;
    if (visible_0) begin
      rd_addr_0 = ({7'd0, row_0} << 6) + ({7'd0, row_0} << 4) + {5'd0, col_0};
    end
    wr_en = term_if.terminal_write && (term_if.terminal_addr < RAM_LIMIT);

    s1_meta_d.valid   = 1'b1;
    s1_meta_d.visible = visible_0;
    s1_meta_d.hsync   = !((h_count_q >= H_SYNC_FIRST) && (h_count_q <= H_SYNC_LAST));
    s1_meta_d.vsync   = !((v_count_q >= V_SYNC_FIRST) && (v_count_q <= V_SYNC_LAST));
    s1_meta_d.hpix    = h_count_q[2:0];
    s1_row_d          = v_count_q[3:0];
  end

  // Read-first: a same-cycle write to the scanned cell shows up on its next read.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      ram_q[term_if.terminal_addr] <= term_if.terminal_data;
    end
    s1_char_q <= ram_q[rd_addr_0];
  end

  always_comb begin
    s2_meta_d  = s1_meta_q;
    s2_blank_d = (s1_char_q == 8'h00);
`ifdef TERMINAL_INVERSE_EN
    font_addr_d = {1'b0, s1_char_q[6:0], s1_row_q};
    s2_inv_d    = s1_char_q[7];
    s2_solid_d  = (s1_char_q == 8'h80);
`else
    font_addr_d = {s1_char_q, s1_row_q};
`endif
  end

  // font_data arrives while stage 3 holds the matching pixel metadata.
  always_comb begin
    glyph_bit = font_data[3'd7 - s3_meta_q.hpix];
`ifdef TERMINAL_INVERSE_EN
    lit = s3_solid_q || (glyph_bit ^ s3_inv_q);
`else
    lit = glyph_bit;
`endif
    rgb_d = 12'h000;
    if (s3_meta_q.valid && s3_meta_q.visible) begin
      rgb_d = (lit && !s3_blank_q) ? FG_COLOR : BG_COLOR;
    end
    hsync_d = s3_meta_q.hsync;
    vsync_d = s3_meta_q.vsync;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_count_q   <= 10'd0;
      v_count_q   <= 10'd0;
      s1_meta_q   <= META_RESET;
      s1_row_q    <= 4'd0;
      s2_meta_q   <= META_RESET;
      font_addr_q <= 12'd0;
      s2_blank_q  <= 1'b1;
      s3_meta_q   <= META_RESET;
      s3_blank_q  <= 1'b1;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      rgb_q       <= 12'h000;
`ifdef TERMINAL_INVERSE_EN
      s2_inv_q    <= 1'b0;
      s2_solid_q  <= 1'b0;
      s3_inv_q    <= 1'b0;
      s3_solid_q  <= 1'b0;
`endif
    end else begin
      h_count_q   <= h_count_d;
      v_count_q   <= v_count_d;
      s1_meta_q   <= s1_meta_d;
      s1_row_q    <= s1_row_d;
      s2_meta_q   <= s2_meta_d;
      font_addr_q <= font_addr_d;
      s2_blank_q  <= s2_blank_d;
      s3_meta_q   <= s2_meta_q;
      s3_blank_q  <= s2_blank_q;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      rgb_q       <= rgb_d;
`ifdef TERMINAL_INVERSE_EN
      s2_inv_q    <= s2_inv_d;
      s2_solid_q  <= s2_solid_d;
      s3_inv_q    <= s2_inv_q;
      s3_solid_q  <= s2_solid_q;
`endif
    end
  end

  assign font_addr = font_addr_q;
  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign vga_red   = rgb_q[11:8];
  assign vga_green = rgb_q[7:4];
  assign vga_blue  = rgb_q[3:0];

endmodule

// File: tb/tb_terminal_display.sv
// Bench for terminal_display: scoreboarded pixel checks and sync timing over one frame.
module tb_terminal_display;

  localparam logic [11:0] FG = 12'h0F0;
  localparam logic [11:0] BG = 12'h000;
  localparam int LINE = 800;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        vga_hsync, vga_vsync;
  logic [3:0]  vga_red, vga_green, vga_blue;

  terminal_display_if tif ();

  terminal_display dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .term_if   (tif),
    .font_addr (font_addr),
    .font_data (font_data),
    .vga_hsync (vga_hsync),
    .vga_vsync (vga_vsync),
    .vga_red   (vga_red),
    .vga_green (vga_green),
    .vga_blue  (vga_blue)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    int          h;
    int          v;
    logic [11:0] rgb;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  // cyc = posedges since reset release = counter value the DUT holds this cycle.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic logic [7:0] rom_f(input logic [11:0] a);
    if (a == 12'h410)      return 8'hA5;
    if (a[11:4] == 8'h00)  return 8'hFF;
    return a[11:4] ^ {a[3:0], a[3:0]} ^ 8'h5A;
  endfunction

  always @(posedge clock) font_data <= rom_f(font_addr);

  function automatic logic [11:0] px(input logic [7:0] ch, input int h, input int v);
    logic [7:0] g;
    logic       inv;
    if (h >= 640 || v >= 480) return 12'h000;
    if (ch == 8'h00) return BG;
`ifdef TERMINAL_INVERSE_EN
    if (ch == 8'h80) return FG;
    g   = rom_f({1'b0, ch[6:0], 4'(v % 16)});
    inv = ch[7];
`else
    g   = rom_f({ch, 4'(v % 16)});
    inv = 1'b0;
`endif
    return (g[7 - (h % 8)] ^ inv) ? FG : BG;
  endfunction

  function automatic exp_t mk(input int h, input int v, input logic [11:0] rgb);
    exp_t e;
    e.due = v * LINE + h + 4;
    e.h   = h;
    e.v   = v;
    e.rgb = rgb;
    return e;
  endfunction

  task automatic wait_cyc(input int t);
    if (cyc > t) begin
      n_errors++;
      $display("FAIL schedule: now at cycle %0d, wanted cycle %0d", cyc, t);
    end
    while (cyc < t) @(negedge clock);
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    tif.terminal_addr  = a;
    tif.terminal_data  = d;
    tif.terminal_write = 1'b1;
    @(negedge clock);
    tif.terminal_write = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({vga_hsync, vga_vsync} !== 2'b11) begin
      n_errors++; $display("FAIL reset_sync: got %b required 11", {vga_hsync, vga_vsync});
    end
    n_checks++;
    obs = {vga_red, vga_green, vga_blue};
    if (obs !== 12'h000) begin n_errors++; $display("FAIL reset_rgb: got %h required 000", obs); end
    n_checks++;
    if (font_addr !== 12'h000) begin
      n_errors++; $display("FAIL reset_font_addr: got %h required 000", font_addr);
    end
    reset_n = 1'b1;
    wr(12'd0, 8'h41);
    wr(12'd1, 8'h00);
    wr(12'd352, 8'h00);
    wr(12'd81, 8'h31);
    wr(12'd2399, 8'h42);
    wr(12'd2400, 8'h43);
    wr(12'd402, 8'hC1);
    wr(12'd403, 8'h80);
    wait_cyc(LINE + 8);
    obs = {vga_red, vga_green, vga_blue};
    n_checks++;
    if (obs !== px(8'h41, 4, 1)) begin
      n_errors++; $display("FAIL premid_rgb: got %h required %h", obs, px(8'h41, 4, 1));
    end
    #2 reset_n = 1'b0;
    #1;
    obs = {vga_red, vga_green, vga_blue};
    n_checks++;
    if ({vga_hsync, vga_vsync} !== 2'b11) begin
      n_errors++; $display("FAIL midreset_sync: got %b required 11", {vga_hsync, vga_vsync});
    end
    n_checks++;
    if (obs !== 12'h000) begin n_errors++; $display("FAIL midreset_rgb: got %h required 000", obs); end
    n_checks++;
    if (font_addr !== 12'h000) begin
      n_errors++; $display("FAIL midreset_font_addr: got %h required 000", font_addr);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_glyph();
    exp_t        e;
    logic [7:0]  pat;
    logic [11:0] obs;
    pat = 8'hA5;
    for (int i = 0; i < 8; i++)  sb.push_back(mk(i, 0, pat[7 - i] ? FG : BG));
    for (int i = 8; i < 16; i++) sb.push_back(mk(i, 0, BG));
    wait_cyc(2);
    n_checks++;
    if (font_addr !== 12'h410) begin
      n_errors++; $display("FAIL glyph_font_addr: got %h required 410", font_addr);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_cyc(e.due);
      obs = {vga_red, vga_green, vga_blue};
      n_checks++;
      if (obs !== e.rgb) begin
        n_errors++; $display("FAIL glyph h=%0d v=%0d: got %h required %h", e.h, e.v, obs, e.rgb);
      end
    end
  endtask

  task automatic test_sync();
    int t;
    int low;
    t = 0;
    while (vga_hsync !== 1'b0 && t < 2000) begin @(negedge clock); t++; end
    n_checks++;
    if (cyc !== 660) begin n_errors++; $display("FAIL hsync_first_fall: got cycle %0d required 660", cyc); end
    low = 0;
    while (vga_hsync === 1'b0 && low < 2000) begin @(negedge clock); low++; end
    n_checks++;
    if (low !== 96) begin n_errors++; $display("FAIL hsync_width: got %0d required 96", low); end
    t = 0;
    while (vga_hsync !== 1'b0 && t < 2000) begin @(negedge clock); t++; end
    n_checks++;
    if (cyc !== LINE + 660) begin
      n_errors++; $display("FAIL hsync_period: got cycle %0d required %0d", cyc, LINE + 660);
    end
  endtask

  task automatic test_same_cycle();
    exp_t        e;
    logic [11:0] obs;
    for (int h = 8; h < 16; h++) sb.push_back(mk(h, 16, px(8'h31, h, 16)));
    for (int h = 8; h < 16; h++) sb.push_back(mk(h, 17, px(8'h32, h, 17)));
    fork
      begin
        wait_cyc(16 * LINE + 15);
        wr(12'd81, 8'h32);
      end
      begin
        while (sb.size() > 0) begin
          e = sb.pop_front();
          wait_cyc(e.due);
          obs = {vga_red, vga_green, vga_blue};
          n_checks++;
          if (obs !== e.rgb) begin
            n_errors++; $display("FAIL same_cycle h=%0d v=%0d: got %h required %h", e.h, e.v, obs, e.rgb);
          end
        end
      end
    join
  endtask

  task automatic test_bad_addr();
    exp_t        e;
    logic [11:0] obs;
    for (int h = 256; h < 264; h++) sb.push_back(mk(h, 64, BG));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_cyc(e.due);
      obs = {vga_red, vga_green, vga_blue};
      n_checks++;
      if (obs !== e.rgb) begin
        n_errors++; $display("FAIL bad_addr h=%0d v=%0d: got %h required %h", e.h, e.v, obs, e.rgb);
      end
    end
  endtask

  task automatic test_inverse();
    exp_t        e;
    logic [11:0] obs;
    logic [11:0] fa_c1, fa_80;
`ifdef TERMINAL_INVERSE_EN
    fa_c1 = 12'h410;
    fa_80 = 12'h00F;
`else
    fa_c1 = 12'hC10;
    fa_80 = 12'h80F;
`endif
    for (int h = 16; h < 24; h++) sb.push_back(mk(h, 80, px(8'hC1, h, 80)));
    for (int h = 24; h < 32; h++) sb.push_back(mk(h, 80, px(8'h80, h, 80)));
    wait_cyc(80 * LINE + 16 + 2);
    n_checks++;
    if (font_addr !== fa_c1) begin
      n_errors++; $display("FAIL inverse_font_addr: got %h required %h", font_addr, fa_c1);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_cyc(e.due);
      obs = {vga_red, vga_green, vga_blue};
      n_checks++;
      if (obs !== e.rgb) begin
        n_errors++; $display("FAIL inverse h=%0d v=%0d: got %h required %h", e.h, e.v, obs, e.rgb);
      end
    end
    wait_cyc(95 * LINE + 24 + 2);
    n_checks++;
    if (font_addr !== fa_80) begin
      n_errors++; $display("FAIL solid_font_addr: got %h required %h", font_addr, fa_80);
    end
  endtask

  task automatic test_last_cell();
    exp_t        e;
    logic [11:0] obs;
    for (int h = 632; h < 641; h++) sb.push_back(mk(h, 464, px(8'h42, h, 464)));
    for (int h = 632; h < 640; h++) sb.push_back(mk(h, 479, px(8'h42, h, 479)));
    sb.push_back(mk(632, 480, 12'h000));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_cyc(e.due);
      obs = {vga_red, vga_green, vga_blue};
      n_checks++;
      if (obs !== e.rgb) begin
        n_errors++; $display("FAIL last_cell h=%0d v=%0d: got %h required %h", e.h, e.v, obs, e.rgb);
      end
    end
  endtask

  task automatic test_vsync();
    int t;
    int low;
    t = 0;
    while (vga_vsync !== 1'b0 && t < 20000) begin @(negedge clock); t++; end
    n_checks++;
    if (cyc !== 490 * LINE + 4) begin
      n_errors++; $display("FAIL vsync_fall: got cycle %0d required %0d", cyc, 490 * LINE + 4);
    end
    low = 0;
    while (vga_vsync === 1'b0 && low < 4000) begin @(negedge clock); low++; end
    n_checks++;
    if (low !== 2 * LINE) begin n_errors++; $display("FAIL vsync_width: got %0d required %0d", low, 2 * LINE); end
  endtask

  initial begin
    tif.terminal_addr  = 12'd0;
    tif.terminal_write = 1'b0;
    tif.terminal_data  = 8'h00;
    reset_n = 1'b0;
    test_reset();
    test_glyph();
    test_sync();
    test_same_cycle();
    test_bad_addr();
    test_inverse();
    test_last_cell();
    test_vsync();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
